// File: rtl/lfsr_share_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_share_ctrl
//
// Shares one Fibonacci LFSR between N_REQ requesters. A round-robin arbiter
// picks one pending requester, the LFSR is advanced STEPS times, and the
// resulting word is handed to that requester with a one-cycle grant pulse.
// Consecutive requesters therefore never see adjacent LFSR states. A seed can
// be loaded while the controller is idle.
//
// Optional feature (compile-time macro):
//   LFSR_SHARE_FREE_RUN_EN - when defined, the LFSR also advances every idle
//                            cycle, so delivered words depend on idle time.
//                            When undefined, the LFSR only advances in STEP.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   req         per-requester request, held high until its gnt pulse
//   gnt         one-hot grant, one-cycle pulse
//   rnd_valid   high together with any gnt bit
//   rnd_data    random word, valid while rnd_valid
//   seed_valid  seed load strobe
//   seed_data   seed value (zero is replaced by 1)
//   seed_ready  high in IDLE; a seed loads when seed_valid && seed_ready
//   busy        high in STEP or DELIVER
// -----------------------------------------------------------------------------
module lfsr_share_ctrl #(
    parameter int               N_REQ    = 4,
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAP_MASK = 4'b1010,
    parameter int               STEPS    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ready,
    output logic             busy
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DELIVER
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_fixed;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] sel_idx_inc;
    logic [N_REQ-1:0] sel;
    logic [7:0]       step_cnt;

    // Arbiter search results
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W:0]   cand;

    assign lfsr_next  = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
    // All-zero is the LFSR lock-up state, so a zero seed is replaced by 1.
    assign seed_fixed = (seed_data == '0) ? WIDTH'(1) : seed_data;
    assign seed_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // Round-robin pointer after serving sel_idx, wrapping N_REQ-1 -> 0.
    assign sel_idx_inc = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // First set request bit at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(N_REQ)) begin
                cand = cand - (PTR_W + 1)'(N_REQ);
            end
            if (!pick_found && req[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= WIDTH'(1);
            rr_ptr    <= '0;
            sel       <= '0;
            sel_idx   <= '0;
            step_cnt  <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            // gnt and rnd_valid are single-cycle pulses unless DELIVER sets them.
            gnt       <= '0;
            rnd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        // Seed wins over req; a pending req is picked up next cycle.
                        lfsr <= seed_fixed;
                    end else begin
`ifdef LFSR_SHARE_FREE_RUN_EN
                        lfsr <= lfsr_next;
`else
                        lfsr <= lfsr;
`endif
                        if (pick_found) begin
                            sel      <= N_REQ'(1) << pick_idx;
                            sel_idx  <= pick_idx;
                            step_cnt <= '0;
                            state    <= STEP;
                        end
                    end
                end
                STEP: begin
                    lfsr     <= lfsr_next;
                    step_cnt <= step_cnt + 8'd1;
                    if (step_cnt == 8'(STEPS - 1)) begin
                        state <= DELIVER;
                    end
                end
                DELIVER: begin
                    gnt       <= sel;
                    rnd_valid <= 1'b1;
                    rnd_data  <= lfsr;
                    rr_ptr    <= sel_idx_inc;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
